// File: rtl/csr_uart_tx_if.sv
// CSR bus bundle for pipeline CSR peripherals.
// The request arrives in cycle N; the write operand and the read response follow in cycle N+1.
interface csr_uart_tx_if;
  logic        read;
  logic [11:0] addr;
  logic [2:0]  modify;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        valid;

  modport master (output read, output addr, output modify, output wdata,
                  input  rdata, input  valid);
  modport slave  (input  read, input  addr, input  modify, input  wdata,
                  output rdata, output valid);
endinterface

// File: rtl/csr_uart_tx.sv
// FIFO-buffered 8N1 UART transmitter behind three CSRs (DATA, STATUS, CTRL).
// It has a runtime baud divisor, a sticky drop-on-full overflow flag and a TX-idle level interrupt.
module csr_uart_tx #(
  parameter logic [11:0] BASE_ADDR   = 12'hBC0,
  parameter int          DEPTH_LOG2  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic         clk,
  input  logic         rst,
  csr_uart_tx_if.slave csr,
  output logic         tx,
  output logic         irq
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_LEVEL  = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE     = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE     = DEPTH_LOG2'(1);
  localparam logic [11:0]           STATUS_ADDR = BASE_ADDR + 12'd1;
  localparam logic [11:0]           CTRL_ADDR   = BASE_ADDR + 12'd2;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  logic                  hit_q;
  logic [11:0]           addr_q;
  logic [16:0]           ctrl_q, ctrl_d;
  logic                  ovf_q, ovf_d;
  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  state_e                state_q;
  logic [7:0]            shift_q;
  logic [15:0]           bitCnt_q;
  logic [2:0]            bitIdx_q;
  logic                  tx_q, irq_q;

  logic        selData, selStatus, selCtrl;
  logic        push, pushOk, pop, ovfClr, full, empty, bitEnd;
  logic [15:0] divEff;
  logic [7:0]  lvl8;
  logic [31:0] rdata;
  logic        unusedWdata;

  assign selData   = hit_q && (addr_q == BASE_ADDR);
  assign selStatus = hit_q && (addr_q == STATUS_ADDR);
  assign selCtrl   = hit_q && (addr_q == CTRL_ADDR);

  assign full   = (level_q == FULL_LEVEL);
  assign empty  = (level_q == '0);
  assign bitEnd = (bitCnt_q == 16'd1);
  assign divEff = (ctrl_q[15:0] == 16'd0) ? 16'd1 : ctrl_q[15:0];

  // The shifter drains a slot in the same cycle, so a push to a full FIFO still fits when a pop coincides.
  assign push   = selData && ((csr.modify == 3'd1) || (csr.modify == 3'd2));
  assign pop    = !empty && ((state_q == IDLE) || ((state_q == STOP) && bitEnd));
  assign pushOk = push && (!full || pop);
  assign ovfClr = selStatus && ((csr.modify == 3'd1) || (csr.modify == 3'd3)) && csr.wdata[3];

  assign unusedWdata = ^csr.wdata[31:17];

  always_comb begin
    ctrl_d = ctrl_q;
    if (selCtrl) begin
      case (csr.modify)
        3'd1:    ctrl_d = csr.wdata[16:0];
        3'd2:    ctrl_d = ctrl_q | csr.wdata[16:0];
        3'd3:    ctrl_d = ctrl_q & ~csr.wdata[16:0];
        default: ctrl_d = ctrl_q;
      endcase
    end

    ovf_d = ovf_q;
    if (ovfClr)
      ovf_d = 1'b0;
    if (push && !pushOk)
      ovf_d = 1'b1;

    wrPtr_d = pushOk ? wrPtr_q + PTR_ONE : wrPtr_q;
    rdPtr_d = pop ? rdPtr_q + PTR_ONE : rdPtr_q;
    level_d = level_q;
    if (pushOk && !pop)
      level_d = level_q + LVL_ONE;
    else if (!pushOk && pop)
      level_d = level_q - LVL_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q   <= 1'b0;
      addr_q  <= 12'd0;
      ctrl_q  <= {1'b0, DEFAULT_DIV};
      ovf_q   <= 1'b0;
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      hit_q   <= csr.read;
      if (csr.read)
        addr_q <= csr.addr;
      ctrl_q  <= ctrl_d;
      ovf_q   <= ovf_d;
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (pushOk)
      mem_q[wrPtr_q] <= csr.wdata[7:0];
  end

  // The bit counter reloads from CTRL at every bit start, so a divisor change lands on the next bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shift_q  <= 8'd0;
      bitCnt_q <= 16'd0;
      bitIdx_q <= 3'd0;
      tx_q     <= 1'b1;
      irq_q    <= 1'b0;
    end else begin
      irq_q <= ctrl_q[16] && empty && (state_q == IDLE);
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q  <= mem_q[rdPtr_q];
            bitCnt_q <= divEff;
            tx_q     <= 1'b0;
            state_q  <= START;
          end
        end
        START: begin
          if (bitEnd) begin
            bitCnt_q <= divEff;
            bitIdx_q <= 3'd0;
            tx_q     <= shift_q[0];
            state_q  <= DATA;
          end else begin
            bitCnt_q <= bitCnt_q - 16'd1;
          end
        end
        DATA: begin
          if (bitEnd) begin
            bitCnt_q <= divEff;
            if (bitIdx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              shift_q  <= shift_q >> 1;
              tx_q     <= shift_q[1];
              bitIdx_q <= bitIdx_q + 3'd1;
            end
          end else begin
            bitCnt_q <= bitCnt_q - 16'd1;
          end
        end
        STOP: begin
          if (bitEnd) begin
            if (pop) begin
              shift_q  <= mem_q[rdPtr_q];
              bitCnt_q <= divEff;
              tx_q     <= 1'b0;
              state_q  <= START;
            end else begin
              tx_q    <= 1'b1;
              state_q <= IDLE;
            end
          end else begin
            bitCnt_q <= bitCnt_q - 16'd1;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    lvl8  = 8'(level_q);
    rdata = 32'd0;
    if (selStatus)
      rdata = {20'd0, lvl8, ovf_q, (state_q != IDLE), empty, full};
    else if (selCtrl)
      rdata = {15'd0, ctrl_q};
  end

  assign csr.rdata = rdata;
  assign csr.valid = selData || selStatus || selCtrl;
  assign tx        = tx_q;
  assign irq       = irq_q;
endmodule
